// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus.
// Groups the decode/execute/memory hazard inputs and the stall, flush and
// forwarding outputs of hazard_ctrl.
//   master : pipeline side, drives hazard sources, receives controls
//   slave  : hazard_ctrl side
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             id_valid;
  logic [4:0]       id_src_a;
  logic [4:0]       id_src_b;
  logic             id_uses_a;
  logic             id_uses_b;
  logic [4:0]       idex_dst_low;
  logic [4:0]       idex_dst_high;
  logic [1:0]       idex_reg_wen;
  logic             idex_is_load;
  logic [4:0]       exmem_dst_low;
  logic [4:0]       exmem_dst_high;
  logic [1:0]       exmem_reg_wen;
  logic             mem_req;
  logic             mem_ack;
  logic             ex_branch_taken;
  logic             stall_if;
  logic             stall_id;
  logic             stall_mem;
  logic             bubble_ex;
  logic             flush_if_id;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_count;
  logic             timeout_err;

  modport master (
    output id_valid, id_src_a, id_src_b, id_uses_a, id_uses_b,
           idex_dst_low, idex_dst_high, idex_reg_wen, idex_is_load,
           exmem_dst_low, exmem_dst_high, exmem_reg_wen,
           mem_req, mem_ack, ex_branch_taken,
    input  stall_if, stall_id, stall_mem, bubble_ex, flush_if_id,
           fwd_a, fwd_b, stall_count, timeout_err
  );

  modport slave (
    input  id_valid, id_src_a, id_src_b, id_uses_a, id_uses_b,
           idex_dst_low, idex_dst_high, idex_reg_wen, idex_is_load,
           exmem_dst_low, exmem_dst_high, exmem_reg_wen,
           mem_req, mem_ack, ex_branch_taken,
    output stall_if, stall_id, stall_mem, bubble_ex, flush_if_id,
           fwd_a, fwd_b, stall_count, timeout_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller.
// Sequences load-use stalls, multi-cycle memory waits (with timeout) and
// taken-branch flushes, and produces registered operand-forwarding selects.
// Ports:
//   clock  : system clock
//   nreset : synchronous active-low reset
//   hz     : hazard_ctrl_if slave (hazard sources in, stall/flush/fwd out)
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic         clock,
  input  logic         nreset,
  hazard_ctrl_if.slave hz
);
  localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [15:0] TMO_MAX    = 16'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [15:0]      tmo_cnt_q, tmo_cnt_d;
  logic             pend_br_q, pend_br_d;
  logic             tmo_err_q, tmo_err_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [1:0][1:0]  fwd_q;

  logic stall_if_c, stall_id_c, stall_mem_c, bubble_c, flush_c;

  // Register 0 is hardwired zero, so it never creates a dependency.
  function automatic logic dst_match(input logic [4:0] addr, lo, hi,
                                     input logic [1:0] wen);
    return (addr != 5'd0) && (((addr == lo) && wen[0]) || ((addr == hi) && wen[1]));
  endfunction

  logic [1:0][4:0] src;
  logic [1:0]      uses;
  logic [1:0]      idex_hit;
  logic [1:0]      exmem_hit;
  logic [1:0][1:0] fwd_sel;
  logic            load_use;

  assign src[0]  = hz.id_src_a;
  assign src[1]  = hz.id_src_b;
  assign uses[0] = hz.id_uses_a;
  assign uses[1] = hz.id_uses_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      assign idex_hit[gi]  = uses[gi] && dst_match(src[gi], hz.idex_dst_low,
                                                   hz.idex_dst_high, hz.idex_reg_wen);
      assign exmem_hit[gi] = uses[gi] && dst_match(src[gi], hz.exmem_dst_low,
                                                   hz.exmem_dst_high, hz.exmem_reg_wen);
      // The younger producer (ID/EX, about to be in EX/MEM) wins.
      assign fwd_sel[gi]   = idex_hit[gi]  ? 2'b01 :
                             exmem_hit[gi] ? 2'b10 : 2'b00;
    end
  endgenerate

  assign load_use = hz.id_valid && hz.idex_is_load && (|idex_hit);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    pend_br_d   = pend_br_q;
    tmo_err_d   = tmo_err_q;
    stall_if_c  = 1'b0;
    stall_id_c  = 1'b0;
    stall_mem_c = 1'b0;
    bubble_c    = 1'b0;
    flush_c     = 1'b0;

    case (state_q)
      // LD_STALL lasts one cycle and then behaves as RUN, except that the
      // load-use check is skipped (the load has already moved on).
      RUN, LD_STALL: begin
        state_d = RUN;
        if (hz.mem_req && !hz.mem_ack) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          stall_mem_c = 1'b1;
          state_d     = MEM_WAIT;
          tmo_cnt_d   = 16'd1;  // the entry cycle counts as a wait cycle
          pend_br_d   = hz.ex_branch_taken;
        end else if (hz.ex_branch_taken) begin
          flush_c     = 1'b1;
          bubble_c    = 1'b1;
          state_d     = (FLUSH_INIT > 3'd1) ? FLUSH : RUN;
          flush_cnt_d = FLUSH_INIT - 3'd1;
        end else if ((state_q == RUN) && load_use) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          bubble_c    = 1'b1;
          state_d     = LD_STALL;
        end
      end

      MEM_WAIT: begin
        if (hz.mem_ack || (tmo_cnt_q == TMO_MAX)) begin
          // Ack takes precedence over a coincident timeout.
          tmo_err_d   = tmo_err_q | !hz.mem_ack;
          tmo_cnt_d   = 16'd0;
          pend_br_d   = 1'b0;
          if (pend_br_q || hz.ex_branch_taken) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end else begin
            state_d     = RUN;
          end
        end else begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          stall_mem_c = 1'b1;
          tmo_cnt_d   = tmo_cnt_q + 16'd1;
          if (hz.ex_branch_taken) pend_br_d = 1'b1;
        end
      end

      FLUSH: begin
        // Branches seen here are ignored.
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        if (flush_cnt_q <= 3'd1) begin
          state_d     = RUN;
          flush_cnt_d = 3'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end

      default: state_d = RUN;
    endcase

    // Controls are held low while reset is asserted.
    if (!nreset) begin
      stall_if_c  = 1'b0;
      stall_id_c  = 1'b0;
      stall_mem_c = 1'b0;
      bubble_c    = 1'b0;
      flush_c     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      pend_br_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      fwd_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      pend_br_q   <= pend_br_d;
      tmo_err_q   <= tmo_err_d;
      if (stall_if_c && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      // Selects follow the instruction entering EX; a bubble carries none.
      if (!stall_id_c)
        fwd_q <= bubble_c ? '0 : fwd_sel;
    end
  end

  assign hz.stall_if    = stall_if_c;
  assign hz.stall_id    = stall_id_c;
  assign hz.stall_mem   = stall_mem_c;
  assign hz.bubble_ex   = bubble_c;
  assign hz.flush_if_id = flush_c;
  assign hz.fwd_a       = fwd_q[0];
  assign hz.fwd_b       = fwd_q[1];
  assign hz.stall_count = stall_cnt_q;
  assign hz.timeout_err = tmo_err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=8).
// Each table row is one clock cycle: inputs driven after the rising edge,
// outputs compared at the falling edge.
module tb_hazard_ctrl;
  logic clock = 1'b0;
  logic nreset;
  always #5 clock = ~clock;

  hazard_ctrl_if #(.CNT_W(16)) hz ();

  hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clock  (clock),
    .nreset (nreset),
    .hz     (hz)
  );

  typedef struct {
    string      name;
    logic       nrst;
    logic       valid;
    logic [4:0] sa;
    logic       ua;
    logic [4:0] sb;
    logic       ub;
    logic [4:0] idl, idh;
    logic [1:0] iwen;
    logic       ild;
    logic [4:0] exl, exh;
    logic [1:0] ewen;
    logic       req, ack, br;
    logic [4:0] ctl;   // {stall_if, stall_id, stall_mem, bubble_ex, flush_if_id}
    logic [1:0] fa, fb;
    logic [15:0] cnt;
    logic       err;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(string nm, logic nrst, logic valid,
      logic [4:0] sa, logic ua, logic [4:0] sb, logic ub,
      logic [4:0] idl, logic [4:0] idh, logic [1:0] iwen, logic ild,
      logic [4:0] exl, logic [4:0] exh, logic [1:0] ewen,
      logic req, logic ack, logic br,
      logic [4:0] ctl, logic [1:0] fa, logic [1:0] fb, logic [15:0] cnt, logic err);
    vec_t v;
    v.name = nm; v.nrst = nrst; v.valid = valid;
    v.sa = sa; v.ua = ua; v.sb = sb; v.ub = ub;
    v.idl = idl; v.idh = idh; v.iwen = iwen; v.ild = ild;
    v.exl = exl; v.exh = exh; v.ewen = ewen;
    v.req = req; v.ack = ack; v.br = br;
    v.ctl = ctl; v.fa = fa; v.fb = fb; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    nreset                = v.nrst;
    hz.id_valid           = v.valid;
    hz.id_src_a           = v.sa;
    hz.id_uses_a          = v.ua;
    hz.id_src_b           = v.sb;
    hz.id_uses_b          = v.ub;
    hz.idex_dst_low       = v.idl;
    hz.idex_dst_high      = v.idh;
    hz.idex_reg_wen       = v.iwen;
    hz.idex_is_load       = v.ild;
    hz.exmem_dst_low      = v.exl;
    hz.exmem_dst_high     = v.exh;
    hz.exmem_reg_wen      = v.ewen;
    hz.mem_req            = v.req;
    hz.mem_ack            = v.ack;
    hz.ex_branch_taken    = v.br;
  endtask

  function automatic logic [31:0] dut_word();
    return {6'd0, hz.stall_if, hz.stall_id, hz.stall_mem, hz.bubble_ex,
            hz.flush_if_id, hz.fwd_a, hz.fwd_b, hz.stall_count, hz.timeout_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end else begin
      $display("vec %-12s ok   value %h", nm, got);
    end
  endtask

  vec_t idle_v;

  initial begin
    idle_v = mk("idle", 1, 0, 0,0, 0,0, 0,0,2'b00,0, 0,0,2'b00, 0,0,0, 5'b0,0,0,0,0);
    drive(idle_v);
    nreset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    //          name           rst vld sa ua sb ub idl idh iwen  ld exl exh ewen  rq ak br  ctl      fa fb cnt er
    vq.push_back(mk("rst",       0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
    vq.push_back(mk("idle0",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
    vq.push_back(mk("lu_det",    1, 1, 5, 1, 0, 0, 5, 0, 2'b01, 1, 0, 0, 2'b00, 0, 0, 0, 5'b11010, 0, 0, 0, 0));
    vq.push_back(mk("lu_stall",  1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 0, 5, 0, 2'b01, 0, 0, 0, 5'b00000, 0, 0, 1, 0));
    vq.push_back(mk("lu_fwd",    1, 1, 0, 0, 9, 1, 0, 9, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 2, 0, 1, 0));
    vq.push_back(mk("fwdb_idex", 1, 1, 0, 0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 0, 1, 1, 0));
    vq.push_back(mk("fwdb_zero", 1, 1, 7, 1, 0, 0, 7, 0, 2'b01, 0, 7, 0, 2'b01, 0, 0, 0, 5'b00000, 0, 0, 1, 0));
    vq.push_back(mk("fwd_prio",  1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 0, 0, 7, 2'b10, 0, 0, 0, 5'b00000, 1, 0, 1, 0));
    vq.push_back(mk("fwd_exhi",  1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 2, 0, 1, 0));
    vq.push_back(mk("idle1",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 1, 0));
    vq.push_back(mk("mw1",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 5'b11100, 0, 0, 1, 0));
    vq.push_back(mk("mw2_br",    1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 1, 5'b11100, 0, 0, 2, 0));
    vq.push_back(mk("mw3",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 5'b11100, 0, 0, 3, 0));
    vq.push_back(mk("mw4",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 5'b11100, 0, 0, 4, 0));
    vq.push_back(mk("mw_ack",    1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 5'b00000, 0, 0, 5, 0));
    vq.push_back(mk("pfl1",      1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00011, 0, 0, 5, 0));
    vq.push_back(mk("pfl2",      1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00011, 0, 0, 5, 0));
    vq.push_back(mk("pfl_end",   1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 5, 0));
    vq.push_back(mk("br_run",    1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 5'b00011, 0, 0, 5, 0));
    vq.push_back(mk("br_in_fl",  1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 5'b00011, 0, 0, 5, 0));
    vq.push_back(mk("br_end",    1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 5, 0));
    vq.push_back(mk("br_lu",     1, 1, 5, 1, 0, 0, 5, 0, 2'b01, 1, 0, 0, 2'b00, 0, 0, 1, 5'b00011, 0, 0, 5, 0));
    vq.push_back(mk("br_lu_fl2", 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00011, 0, 0, 5, 0));
    vq.push_back(mk("idle2",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 5, 0));
    vq.push_back(mk("req_ack",   1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 5'b00000, 0, 0, 5, 0));
    vq.push_back(mk("mw_over_lu",1, 1, 5, 1, 0, 0, 5, 0, 2'b01, 1, 0, 0, 2'b00, 1, 0, 0, 5'b11100, 0, 0, 5, 0));
    vq.push_back(mk("mw_lu_ack", 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 5'b00000, 0, 0, 6, 0));
    vq.push_back(mk("idle3",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 6, 0));
    vq.push_back(mk("mw_br_ent", 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 1, 5'b11100, 0, 0, 6, 0));
    vq.push_back(mk("mw_br_ack", 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 5'b00000, 0, 0, 7, 0));
    vq.push_back(mk("efl1",      1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00011, 0, 0, 7, 0));
    vq.push_back(mk("efl2",      1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00011, 0, 0, 7, 0));
    vq.push_back(mk("idle4",     1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 7, 0));

    foreach (vq[i]) begin
      drive(vq[i]);
      @(negedge clock);
      chk(vq[i].name, dut_word(),
          {6'd0, vq[i].ctl, vq[i].fa, vq[i].fb, vq[i].cnt, vq[i].err});
      @(posedge clock);
      #1;
    end

    // Memory timeout: no ack, stalls hold for MEM_TIMEOUT cycles then drop.
    drive(idle_v);
    hz.mem_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("tmo_wait%0d", i), {29'd0, hz.stall_if, hz.stall_id, hz.stall_mem}, 32'd7);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk("tmo_exit", {29'd0, hz.stall_if, hz.stall_mem, hz.timeout_err}, 32'd0);
    @(posedge clock);
    #1;
    hz.mem_req = 1'b0;
    @(negedge clock);
    chk("tmo_err", {15'd0, hz.stall_count, hz.timeout_err}, {15'd0, 16'd15, 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      chk($sformatf("tmo_sticky%0d", i), {31'd0, hz.timeout_err}, 32'd1);
    end
    @(posedge clock);
    #1;

    // Reset in the middle of a flush abandons it.
    hz.ex_branch_taken = 1'b1;
    @(negedge clock);
    chk("rf_br", {30'd0, hz.flush_if_id, hz.bubble_ex}, 32'd3);
    @(posedge clock);
    #1;
    hz.ex_branch_taken = 1'b0;
    nreset = 1'b0;
    @(negedge clock);
    chk("rf_in_rst", {30'd0, hz.flush_if_id, hz.bubble_ex}, 32'd0);
    @(posedge clock);
    #1;
    nreset = 1'b1;
    @(negedge clock);
    chk("rf_after", dut_word(), 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("rf_run", dut_word(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
